// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue sequencer: op codes, FSM states and
// the per-op latency table that the cycle counter is loaded from.
package fpu_issue_ctrl_pkg;

  localparam int FPUOP_W = 5;
  localparam int LAT_MAX = 15;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [FPUOP_W-1:0] {
    FADD  = 5'd0,
    FSUB  = 5'd1,
    FMUL  = 5'd2,
    FDIV  = 5'd3,
    FSQRT = 5'd4,
    FSGNJ = 5'd5,
    FCVT  = 5'd6
  } fpuop_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Cycles from fpu_start to the completion cycle; never 0 and never above
  // LAT_MAX. Unknown codes behave like the shortest op.
  function automatic logic [LAT_W-1:0] fpu_latency(input logic [FPUOP_W-1:0] op);
    case (op)
      FADD, FSUB, FMUL: fpu_latency = LAT_W'(2);
      FDIV:             fpu_latency = LAT_W'(10);
      FSQRT:            fpu_latency = LAT_W'(8);
      FSGNJ:            fpu_latency = LAT_W'(1);
      FCVT:             fpu_latency = LAT_W'(2);
      default:          fpu_latency = LAT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Issue, FPU and writeback signals of the exec-stage FPU sequencer.
// master = surrounding pipeline/FPU, slave = the sequencer.
interface fpu_issue_ctrl_if;
  import fpu_issue_ctrl_pkg::*;

  logic               issue_valid;
  logic [FPUOP_W-1:0] issue_fpuop;
  logic [5:0]         issue_rd;
  logic               issue_ready;
  logic               stall;

  logic               fpu_start;
  logic [FPUOP_W-1:0] fpu_op;
  logic               fpu_fin;
  logic [31:0]        fpu_result;

  logic               wb_valid;
  logic               wb_ready;
  logic [5:0]         wb_rd;
  logic [31:0]        wb_result;

  modport master (
    output issue_valid, issue_fpuop, issue_rd, fpu_fin, fpu_result, wb_ready,
    input  issue_ready, stall, fpu_start, fpu_op, wb_valid, wb_rd, wb_result
  );

  modport slave (
    input  issue_valid, issue_fpuop, issue_rd, fpu_fin, fpu_result, wb_ready,
    output issue_ready, stall, fpu_start, fpu_op, wb_valid, wb_rd, wb_result
  );

endinterface

// File: rtl/fpu_issue_ctrl_lat_counter.sv
// Down-counter for FPU latency: load wins over decrement, and it saturates
// at zero so it can never wrap.
module fpu_issue_ctrl_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  // Counter register: load a new latency or step down towards zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequencer for the multi-cycle FPU: accepts one op at a time, pulses
// fpu_start, times the op with a latency counter, captures the result at
// count zero and holds it for writeback. A flush while the FPU is working
// lets the counter run out (DRAIN) so the FPU is never restarted early.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  fpu_issue_ctrl_if.slave   bus,
  output logic              busy,
  output logic              err_lat
);

  state_e             state_q, state_d;
  logic [FPUOP_W-1:0] op_q;
  logic [5:0]         rd_q;
  logic [5:0]         wb_rd_q;
  logic [31:0]        wb_res_q;
  logic               start_q;
  logic               err_q;

  logic               accept;
  logic               in_flight;
  logic               capture;
  logic               cnt_zero;
  logic [LAT_W-1:0]   cnt;
  logic [LAT_W-1:0]   lat_load;

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign bus.issue_ready = rstn & ~flush &
                           ((state_q == IDLE) | ((state_q == DONE) & bus.wb_ready));
  assign bus.stall       = bus.issue_valid & ~bus.issue_ready;
  assign accept          = bus.issue_valid & bus.issue_ready;

  assign in_flight = (state_q == RUN) | (state_q == DRAIN);
  assign capture   = (state_q == RUN) & cnt_zero & ~flush;
  assign lat_load  = fpu_latency(bus.issue_fpuop);

  fpu_issue_ctrl_lat_counter #(.W(LAT_W)) u_lat_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .load_val (lat_load),
    .dec      (in_flight),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next-state logic; sequencing follows the counter, never fpu_fin.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (cnt_zero)   state_d = flush ? IDLE : DONE;
        else if (flush) state_d = DRAIN;
      end
      DRAIN:   if (cnt_zero) state_d = IDLE;
      DONE: begin
        if (flush)             state_d = IDLE;
        else if (bus.wb_ready) state_d = accept ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus op/rd latch, start pulse, result capture and
  // the sticky latency-mismatch flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      wb_rd_q  <= '0;
      wb_res_q <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= accept;
      if (accept) begin
        op_q <= bus.issue_fpuop;
        rd_q <= bus.issue_rd;
      end
      if (capture) begin
        wb_rd_q  <= rd_q;
        wb_res_q <= bus.fpu_result;
      end
      // fin must coincide exactly with the counter reaching zero.
      if (in_flight && (bus.fpu_fin ^ cnt_zero)) err_q <= 1'b1;
    end
  end

  assign bus.fpu_start = start_q;
  assign bus.fpu_op    = op_q;
  assign bus.wb_valid  = (state_q == DONE);
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_result = wb_res_q;
  assign busy          = (state_q != IDLE);
  assign err_lat       = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: the driver pushes the expected
// writeback (rd, result, cycle) when an op is accepted; a monitor pops and
// compares whenever wb_valid rises, and checks hold-stability under
// backpressure. A small FPU model fins after the table latency.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;
  logic busy;
  logic err_lat;

  fpu_issue_ctrl_if bus();

  fpu_issue_ctrl dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .bus     (bus),
    .busy    (busy),
    .err_lat (err_lat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency table as written in the op list.
  function automatic int bench_lat(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2: return 2;
      5'd3:             return 10;
      5'd4:             return 8;
      5'd5:             return 1;
      5'd6:             return 2;
      default:          return 1;
    endcase
  endfunction

  // ---------------- FPU model ----------------
  int          fin_at  = -1;
  int          early   = 0;
  logic [31:0] fin_res = '0;
  logic [31:0] cur_tag = '0;
  logic        fin_now = 1'b0;

  assign bus.fpu_fin    = fin_now;
  assign bus.fpu_result = fin_res;

  always @(negedge clk) begin
    if (!rstn) fin_at = -1;
    else if (bus.fpu_start) begin
      fin_at  = cyc + bench_lat(bus.fpu_op) - early;
      fin_res = cur_tag;
    end
  end

  always @(posedge clk) begin
    #1;
    fin_now = (cyc == fin_at);
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [5:0]  rd;
    logic [31:0] res;
    int          vcyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic        wbv_q = 1'b0;
  logic        wbr_q = 1'b0;
  logic [5:0]  held_rd = '0;
  logic [31:0] held_res = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      wbv_q = 1'b0;
      wbr_q = 1'b0;
    end else begin
      if (bus.wb_valid && !wbv_q) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", 64'(bus.wb_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("wb_rd",     64'(bus.wb_rd),     64'(e.rd));
          check("wb_result", 64'(bus.wb_result), 64'(e.res));
          check("wb_cycle",  64'(cyc),           64'(e.vcyc));
        end
      end else if (bus.wb_valid && wbv_q && !wbr_q) begin
        check("wb_hold", 64'({bus.wb_rd, bus.wb_result}), 64'({held_rd, held_res}));
      end
      wbv_q    = bus.wb_valid;
      wbr_q    = bus.wb_ready;
      held_rd  = bus.wb_rd;
      held_res = bus.wb_result;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op this cycle, check acceptance, and queue its writeback.
  task automatic issue_cycle(input fpuop_e op, input logic [5:0] rd, input logic [31:0] tag,
                             input logic exp_rdy, input bit want_wb, input string name);
    bus.issue_valid = 1'b1;
    bus.issue_fpuop = op;
    bus.issue_rd    = rd;
    cur_tag         = tag;
    @(negedge clk);
    check({name, "_ready"}, 64'(bus.issue_ready), 64'(exp_rdy));
    if (exp_rdy && want_wb)
      sb.push_back('{rd: rd, res: tag, vcyc: cyc + bench_lat(op) + 2});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      step();
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 64'(busy), 64'(0));
    step();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({busy, err_lat, bus.issue_ready, bus.stall, bus.fpu_start, bus.fpu_op,
                     bus.wb_valid, bus.wb_rd, bus.wb_result}), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_fpuop = '0;
    bus.issue_rd    = '0;
    bus.wb_ready    = 1'b0;

    // Reset state.
    step();
    step();
    @(negedge clk);
    check_all_zero("reset_outputs");
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(bus.issue_ready), 64'(1));
    step();

    // FADD then FMUL back-to-back through DONE.
    bus.wb_ready = 1'b1;
    issue_cycle(FADD, 6'd5, 32'h1111_0005, 1'b1, 1'b1, "b2b_first");
    step();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("b2b_start", 64'({bus.fpu_start, bus.fpu_op, busy}), 64'({1'b1, 5'd0, 1'b1}));
    step();
    @(negedge clk);
    check("b2b_start_pulse", 64'(bus.fpu_start), 64'(0));
    step();
    step();
    issue_cycle(FMUL, 6'd7, 32'h2222_0007, 1'b1, 1'b1, "b2b_second");
    step();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_start", 64'({bus.fpu_start, bus.fpu_op}), 64'({1'b1, 5'd2}));
    wait_idle("b2b");

    // FDIV under writeback backpressure, with a held issue stalling.
    bus.wb_ready = 1'b0;
    issue_cycle(FDIV, 6'd9, 32'h3333_0009, 1'b1, 1'b1, "bp");
    step();
    bus.issue_valid = 1'b1;
    bus.issue_fpuop = FADD;
    bus.issue_rd    = 6'd3;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      check("bp_stall", 64'(bus.stall), 64'(1));
      step();
    end
    bus.issue_valid = 1'b0;
    bus.wb_ready    = 1'b1;
    @(negedge clk);
    check("bp_valid_at_20", 64'(bus.wb_valid), 64'(1));
    step();
    bus.wb_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_at_21", 64'({busy, bus.wb_valid}), 64'(0));
    step();

    // Flush mid-RUN of an FSQRT: drain, no writeback, no early restart.
    bus.wb_ready = 1'b1;
    issue_cycle(FSQRT, 6'd11, 32'h4444_000B, 1'b1, 1'b0, "flush_run");
    step();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("flush_run_start", 64'(bus.fpu_start), 64'(1));
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      check("flush_drain", 64'({busy, bus.fpu_start, bus.wb_valid}), 64'({1'b1, 1'b0, 1'b0}));
      step();
    end
    issue_cycle(FADD, 6'd12, 32'h5555_000C, 1'b0, 1'b0, "flush_early");
    check("flush_no_restart", 64'(bus.fpu_start), 64'(0));
    step();
    issue_cycle(FADD, 6'd12, 32'h5555_000C, 1'b1, 1'b1, "flush_new");
    step();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("flush_new_start", 64'({bus.fpu_start, err_lat}), 64'({1'b1, 1'b0}));
    wait_idle("flush_run");

    // Flush in DONE with a same-cycle wb_ready: result dropped, no accept.
    bus.wb_ready = 1'b0;
    issue_cycle(FSGNJ, 6'd20, 32'h6666_0014, 1'b1, 1'b1, "flush_done");
    step();
    bus.issue_valid = 1'b0;
    step();
    step();
    flush        = 1'b1;
    bus.wb_ready = 1'b1;
    issue_cycle(FADD, 6'd21, 32'h7777_0015, 1'b0, 1'b0, "flush_done_issue");
    check("flush_done_valid", 64'(bus.wb_valid), 64'(1));
    step();
    flush           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.wb_ready    = 1'b0;
    @(negedge clk);
    check("flush_done_after", 64'({bus.wb_valid, busy, bus.fpu_start}), 64'(0));
    step();

    // FMUL with the FPU finishing one cycle early.
    bus.wb_ready = 1'b1;
    early        = 1;
    issue_cycle(FMUL, 6'd30, 32'h8888_001E, 1'b1, 1'b1, "lat");
    step();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("lat_err_before", 64'(err_lat), 64'(0));
    step();
    @(negedge clk);
    check("lat_err_fin_cycle", 64'(err_lat), 64'(0));
    step();
    @(negedge clk);
    check("lat_err_set", 64'(err_lat), 64'(1));
    step();
    step();
    early = 0;
    @(negedge clk);
    check("lat_err_sticky", 64'(err_lat), 64'(1));
    wait_idle("lat");

    // Asynchronous reset during an FDIV, then a fresh FADD.
    issue_cycle(FDIV, 6'd40, 32'h9999_0028, 1'b1, 1'b0, "rst_mid");
    step();
    bus.issue_valid = 1'b0;
    step();
    step();
    rstn = 1'b0;
    #1;
    check_all_zero("rst_mid_outputs");
    @(negedge clk);
    step();
    rstn = 1'b1;
    issue_cycle(FADD, 6'd41, 32'hAAAA_0029, 1'b1, 1'b1, "rst_fresh");
    step();
    bus.issue_valid = 1'b0;
    wait_idle("rst_fresh");

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule
